// File: rtl/seq_gen_pkg.sv
// Shared types and seed constants for the multi-mode sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ModeT3    = 2'd0,
        ModeFib   = 2'd1,
        ModeArith = 2'd2,
        ModeTri   = 2'd3
    } seq_mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } seq_state_e;

    // Seeds are all 0/1, so one bit per seed term is enough.
    localparam logic [2:0] T3Seed  = 3'b110;  // a0..a2 = 0,1,1
    localparam logic [1:0] FibSeed = 2'b10;   // a0,a1  = 0,1

    // Number of leading terms taken from the seed rather than the recurrence.
    function automatic logic [1:0] seed_count(seq_mode_e mode);
        case (mode)
            ModeT3:  return 2'd3;
            ModeFib: return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic seed_value(seq_mode_e mode, logic [1:0] idx);
        case (mode)
            ModeT3:  return (idx < 2'd3) ? T3Seed[idx] : 1'b0;
            ModeFib: return (idx < 2'd2) ? FibSeed[idx[0]] : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_gen_next.sv
// Combinational next-term unit: returns {carry, a[n+1]} from the term history.
module seq_gen_next
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STEP_W = 8
) (
    input  seq_mode_e          mode_i,
    input  logic [WIDTH-1:0]   cur_i,     // a[n]
    input  logic [WIDTH-1:0]   prev1_i,   // a[n-1]
    input  logic [WIDTH-1:0]   prev2_i,   // a[n-2]
    input  logic [STEP_W-1:0]  step_i,
    input  logic [15:0]        index_i,   // n
    output logic [WIDTH-1:0]   next_term_o,
    output logic               carry_o
);

    localparam int unsigned SumW = WIDTH + 1;

    logic [SumW-1:0] sum;
    logic [16:0]     idx_inc;

    always_comb begin
        idx_inc = {1'b0, index_i} + 17'd1;
        sum     = '0;
        if (idx_inc < 17'(seed_count(mode_i))) begin
            sum = SumW'(seed_value(mode_i, idx_inc[1:0]));
        end else begin
            unique case (mode_i)
                ModeT3:    sum = {1'b0, cur_i} + {1'b0, prev2_i};
                ModeFib:   sum = {1'b0, cur_i} + {1'b0, prev1_i};
                ModeArith: sum = {1'b0, cur_i} + SumW'(step_i);
                // Triangular adds n+1 to a[n]; no multiplier needed.
                ModeTri:   sum = {1'b0, cur_i} + SumW'(idx_inc);
            endcase
        end
        next_term_o = sum[WIDTH-1:0];
        carry_o     = sum[WIDTH];
    end

endmodule

// File: rtl/seq_gen_multi.sv
// Multi-mode integer sequence generator (T3, Fibonacci, arithmetic, triangular)
// with valid/ready output handshake and wrap-or-stop overflow handling.
module seq_gen_multi
    import seq_gen_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STEP_W = 8,
    parameter bit          WRAP   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              seq_ready_i,
    output logic              seq_valid_o,
    output logic [WIDTH-1:0]  seq_o,
    output logic [15:0]       term_o,
    output logic              ovf_o
);

    seq_state_e          state_q, state_d;
    seq_mode_e           mode_q;
    logic [STEP_W-1:0]   step_q;
    logic [WIDTH-1:0]    hist_q [3];   // [0]=a[n], [1]=a[n-1], [2]=a[n-2]
    logic [15:0]         term_q;
    logic                ovf_q;

    logic [WIDTH-1:0]    next_term;
    logic                carry;
    logic                advance;
    logic                stop;

    seq_gen_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .mode_i      (mode_q),
        .cur_i       (hist_q[0]),
        .prev1_i     (hist_q[1]),
        .prev2_i     (hist_q[2]),
        .step_i      (step_q),
        .index_i     (term_q),
        .next_term_o (next_term),
        .carry_o     (carry)
    );

    assign advance = (state_q == StRun) && seq_ready_i;
    // Without wrapping, an overflowing term is never emitted.
    assign stop    = advance && carry && !WRAP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = StRun;
        end else if (stop) begin
            state_d = StDone;
        end
    end

    always_comb begin
        seq_valid_o = (state_q == StRun);
        seq_o       = hist_q[0];
        term_o      = term_q;
        ovf_o       = ovf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q    <= ModeT3;
            step_q    <= '0;
            hist_q[0] <= '0;
            hist_q[1] <= '0;
            hist_q[2] <= '0;
            term_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (start_i) begin
            mode_q    <= seq_mode_e'(mode_i);
            step_q    <= step_i;
            hist_q[0] <= WIDTH'(seed_value(seq_mode_e'(mode_i), 2'd0));
            hist_q[1] <= '0;
            hist_q[2] <= '0;
            term_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (stop) begin
            ovf_q <= 1'b1;
        end else if (advance) begin
            hist_q[0] <= next_term;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            term_q    <= (term_q == 16'hFFFF) ? term_q : term_q + 16'd1;
            ovf_q     <= ovf_q | carry;
        end
    end

endmodule

// File: tb/tb_seq_gen_multi.sv
// Directed bench for seq_gen_multi: vector table on a 32-bit instance plus
// overflow and asynchronous-reset sequences on 8-bit wrap/stop instances.
module tb_seq_gen_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  step;
    logic        ready;

    logic        valid32, ovf32;
    logic [31:0] seq32;
    logic [15:0] term32;
    logic        valid_s, ovf_s;
    logic [7:0]  seq_s;
    logic [15:0] term_s;
    logic        valid_w, ovf_w;
    logic [7:0]  seq_w;
    logic [15:0] term_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_gen_multi #(.WIDTH(32), .STEP_W(8), .WRAP(1'b1)) dut32 (
        .clk(clk), .reset(reset), .start_i(start), .mode_i(mode), .step_i(step),
        .seq_ready_i(ready), .seq_valid_o(valid32), .seq_o(seq32), .term_o(term32),
        .ovf_o(ovf32)
    );

    seq_gen_multi #(.WIDTH(8), .STEP_W(8), .WRAP(1'b0)) dut8_stop (
        .clk(clk), .reset(reset), .start_i(start), .mode_i(mode), .step_i(step),
        .seq_ready_i(ready), .seq_valid_o(valid_s), .seq_o(seq_s), .term_o(term_s),
        .ovf_o(ovf_s)
    );

    seq_gen_multi #(.WIDTH(8), .STEP_W(8), .WRAP(1'b1)) dut8_wrap (
        .clk(clk), .reset(reset), .start_i(start), .mode_i(mode), .step_i(step),
        .seq_ready_i(ready), .seq_valid_o(valid_w), .seq_o(seq_w), .term_o(term_w),
        .ovf_o(ovf_w)
    );

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic [7:0]  step;
        logic        ready;
        logic        valid;
        logic [31:0] seq;
        logic [15:0] term;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic [1:0] md, input logic [7:0] sp,
                       input logic rd, input logic v, input logic [31:0] s,
                       input logic [15:0] t, input logic o);
        vec_t r;
        r.start = st; r.mode = md; r.step = sp; r.ready = rd;
        r.valid = v;  r.seq = s;   r.term = t;  r.ovf = o;
        vecs.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] t3_exp [12];
        logic [8:0]  fa, fb, fsum;
        int          n;

        t3_exp = '{0, 1, 1, 1, 2, 3, 4, 6, 9, 13, 19, 28};

        // T3 run; mode field changed mid-run must be ignored.
        add(1, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 1; i < 12; i++) begin
            add(0, (i >= 5 && i <= 7) ? 2'd2 : 2'd0, 8'd0, 1, 1, t3_exp[i], 16'(i), 0);
        end
        // Arithmetic step 5 with stalls; step change while stalled is ignored.
        add(1, 2, 5, 1, 1, 0,  0, 0);
        add(0, 2, 5, 1, 1, 5,  1, 0);
        add(0, 2, 9, 0, 1, 5,  1, 0);
        add(0, 2, 9, 0, 1, 5,  1, 0);
        add(0, 2, 9, 1, 1, 10, 2, 0);
        // Triangular, then restart colliding with an accept.
        add(1, 3, 0, 1, 1, 0,  0, 0);
        add(0, 3, 0, 1, 1, 1,  1, 0);
        add(0, 3, 0, 1, 1, 3,  2, 0);
        add(0, 3, 0, 1, 1, 6,  3, 0);
        add(0, 3, 0, 1, 1, 10, 4, 0);
        add(1, 3, 0, 1, 1, 0,  0, 0);
        add(0, 3, 0, 1, 1, 1,  1, 0);

        reset = 1'b0; start = 1'b0; mode = 2'd0; step = 8'd0; ready = 1'b0;
        #1;
        check("reset valid", valid32, 0);
        check("reset seq",   seq32,   0);
        check("reset term",  term32,  0);
        check("reset ovf",   ovf32,   0);
        tick();
        reset = 1'b1;
        ready = 1'b1;
        tick();
        tick();
        check("idle valid", valid32, 0);
        check("idle term",  term32,  0);

        foreach (vecs[i]) begin
            start = vecs[i].start; mode = vecs[i].mode;
            step  = vecs[i].step;  ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d valid", i), valid32, vecs[i].valid);
            check($sformatf("vec%0d seq", i),   seq32,   vecs[i].seq);
            check($sformatf("vec%0d term", i),  term32,  vecs[i].term);
            check($sformatf("vec%0d ovf", i),   ovf32,   vecs[i].ovf);
        end

        // Fibonacci on 8-bit instances: stop vs wrap on 233 + 144.
        start = 1'b1; mode = 2'd1; step = 8'd0; ready = 1'b1;
        tick();
        start = 1'b0;
        fa = 9'd0; fb = 9'd1;
        for (int k = 0; k < 14; k++) begin
            check($sformatf("fib%0d stop seq", k),  seq_s,   fa);
            check($sformatf("fib%0d stop term", k), term_s,  k);
            check($sformatf("fib%0d stop v/o", k),  {valid_s, ovf_s}, 2'b10);
            check($sformatf("fib%0d wrap seq", k),  seq_w,   fa);
            fsum = fa + fb; fa = fb; fb = fsum;
            tick();
        end
        check("fib stop valid", valid_s, 0);
        check("fib stop ovf",   ovf_s,   1);
        check("fib stop seq",   seq_s,   233);
        check("fib stop term",  term_s,  13);
        check("fib wrap seq",   seq_w,   121);
        check("fib wrap ovf",   ovf_w,   1);
        check("fib wrap valid", valid_w, 1);
        check("fib wrap term",  term_w,  14);
        tick();
        tick();
        check("done hold valid", valid_s, 0);
        check("done hold seq",   seq_s,   233);
        check("done hold term",  term_s,  13);
        start = 1'b1; mode = 2'd2; step = 8'd3;
        tick();
        start = 1'b0;
        check("done restart valid", valid_s, 1);
        check("done restart seq",   seq_s,   0);
        check("done restart ovf",   ovf_s,   0);
        tick();
        check("done restart step", seq_s, 3);

        // Asynchronous reset at random points mid-run.
        for (int it = 0; it < 20; it++) begin
            start = 1'b1; mode = 2'($urandom_range(0, 3)); step = 8'($urandom_range(0, 255));
            ready = 1'b1;
            tick();
            start = 1'b0;
            n = $urandom_range(10, 50);
            repeat (n) begin
                ready = 1'($urandom_range(0, 1));
                tick();
            end
            #3 reset = 1'b0;
            #1;
            check($sformatf("arst%0d valid", it), valid32, 0);
            check($sformatf("arst%0d seq", it),   seq32,   0);
            check($sformatf("arst%0d term", it),  term32,  0);
            check($sformatf("arst%0d ovf", it),   ovf32,   0);
            check($sformatf("arst%0d small", it),
                  {valid_s, seq_s, term_s, ovf_s, valid_w, seq_w, term_w, ovf_w}, 0);
            tick();
            reset = 1'b1;
            ready = 1'b1;
            tick();
            tick();
            check($sformatf("arst%0d idle valid", it), valid32, 0);
            check($sformatf("arst%0d idle term", it),  term32,  0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_gen_multi.md
SEQ_GEN_MULTI -- requirements
Module: seq_gen_multi

Interface
REQ-001 Parameter WIDTH, default 32, term width in bits (legal 8..64).
REQ-002 Parameter STEP_W, default 8, width of the arithmetic step input.
REQ-003 Parameter WRAP, default 1: 1 = overflow wraps modulo 2^WIDTH; 0 = overflow stops the sequence.
REQ-004 Port clk  input  1  clock, all state on rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-low.
REQ-006 Port start_i  input  1  synchronous restart pulse; latches mode_i and step_i.
REQ-007 Port mode_i  input  2  sequence select: 0 T3 (a[n]=a[n-1]+a[n-3]), 1 Fibonacci, 2 arithmetic, 3 triangular.
REQ-008 Port step_i  input  STEP_W  increment for mode 2, zero-extended to WIDTH.
REQ-009 Port seq_ready_i  input  1  consumer accepts current term.
REQ-010 Port seq_valid_o  output  1  seq_o holds a valid term.
REQ-011 Port seq_o  output  WIDTH  current term.
REQ-012 Port term_o  output  16  index n of current term, saturating at 16'hFFFF.
REQ-013 Port ovf_o  output  1  sticky overflow flag since last start.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE after reset, seq_valid_o=0 in IDLE and DONE, 1 in RUN.
REQ-015 start_i=1 in any state: next cycle state=RUN, seq_o=a0=0, term_o=0, ovf_o=0, mode/step latched; history loaded with the mode seed.
REQ-016 Seeds: T3 history a0..a2 = 0,1,1; Fibonacci a0,a1 = 0,1; arithmetic a0=0; triangular a0=0.
REQ-017 Mode/step changes while not starting are ignored until the next start_i.
REQ-018 Advance occurs only when state=RUN and seq_valid_o and seq_ready_i: next cycle seq_o=a[n+1], term_o=n+1.
REQ-019 seq_ready_i=0 in RUN: seq_o, term_o, history held unchanged (stall).
REQ-020 start_i has priority over an advance in the same cycle.
REQ-021 Triangular: a[n]=a[n-1]+n, computed with term index, not multiplication.
REQ-022 T3 and Fibonacci seed terms emit from the history before recurrence terms (T3: 0,1,1,1,2,3,4,6,9,...).
REQ-023 Next-term sum computed at WIDTH+1 bits; carry-out = overflow.
REQ-024 WRAP=1 on overflow: emit low WIDTH bits, set ovf_o, stay in RUN.
REQ-025 WRAP=0 on overflow: do not emit the term; on the advancing edge go to DONE, seq_valid_o=0, ovf_o=1, seq_o holds last legal term.
REQ-026 DONE exits only on start_i; seq_ready_i in DONE has no effect.
REQ-027 Latency: one cycle from start_i to first valid term; one cycle from accepted term to next term.

Reset
REQ-028 reset low asynchronously forces IDLE, seq_o=0, term_o=0, ovf_o=0, seq_valid_o=0, history cleared.
REQ-029 reset released mid-sequence: block stays in IDLE until start_i; no term emitted.

Structure
REQ-030 Package seq_gen_pkg holds the mode enum, FSM state enum, and seed constants.
REQ-031 Sub-module seq_gen_next computes {carry, next term} from history, mode, step and index; all registers live in seq_gen_multi.

Verification
REQ-032 WIDTH=32, start mode 0, ready=1 -> seq_o 0,1,1,1,2,3,4,6,9,13,19,28 on consecutive cycles, term_o 0..11.
REQ-033 WIDTH=8, WRAP=0, mode 1, ready=1 -> terms 0..233 (14 terms), then seq_valid_o=0, ovf_o=1, seq_o=233.
REQ-034 WIDTH=8, WRAP=1, mode 1 -> term after 233 is 121, ovf_o=1, seq_valid_o stays 1.
REQ-035 Mode 2 step=5, ready toggled 1,0,0,1 -> seq_o 0,5,5,5,10; term_o tracks accepted terms only.
REQ-036 Mode 3 run 5 terms, then start_i with ready=1 same cycle -> seq_o=0, term_o=0 next cycle (restart wins).
REQ-037 reset asserted at random mid-run (20 iterations, 10..50 cycles apart) -> all outputs 0 immediately, IDLE until start_i.
